// File: rtl/prefix_carry_pipe_pkg.sv
// Shared adder constants, also used by the downstream sum stage.
package prefix_carry_pipe_pkg;

  localparam int unsigned ADDER_N = 8;

endpackage

// File: rtl/prefix_carry_pipe_if.sv
// Operand/result handshake bundle between producer, carry pipe and sum stage.
interface prefix_carry_pipe_if
  import prefix_carry_pipe_pkg::*;
#(
  parameter int unsigned N = ADDER_N
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] P;
  logic [N-1:0] C;
  logic         cout;

  modport master (
    output in_valid, A, B, cin, out_ready,
    input  in_ready, out_valid, P, C, cout
  );

  modport slave (
    input  in_valid, A, B, cin, out_ready,
    output in_ready, out_valid, P, C, cout
  );

endinterface

// File: rtl/prefix_carry_pipe_level.sv
// One registered Kogge-Stone level; black cells on bits >= SPAN, lower bits pass through.
module prefix_level #(
  parameter int unsigned N    = 8,
  parameter int unsigned SPAN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] g_i,
  input  logic [N-1:0] pg_i,
  input  logic [N-1:0] p_i,
  input  logic         cin_i,
  input  logic         valid_i,
  output logic [N-1:0] g_o,
  output logic [N-1:0] pg_o,
  output logic [N-1:0] p_o,
  output logic         cin_o,
  output logic         valid_o
);

  // Bits below SPAN keep their group propagate untouched.
  localparam logic [N-1:0] LOW_MASK = {N{1'b1}} >> (N - SPAN);

  logic [N-1:0] g_d, g_q;
  logic [N-1:0] pg_d, pg_q;
  logic [N-1:0] p_d, p_q;
  logic         cin_d, cin_q;
  logic         valid_d, valid_q;

  always_comb begin
    g_d     = g_q;
    pg_d    = pg_q;
    p_d     = p_q;
    cin_d   = cin_q;
    valid_d = valid_q;
    if (en) begin
      // Shifted-in zeros make the low bits reduce to a plain copy.
      g_d     = g_i | (pg_i & (g_i << SPAN));
      pg_d    = pg_i & ((pg_i << SPAN) | LOW_MASK);
      p_d     = p_i;
      cin_d   = cin_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q     <= '0;
      pg_q    <= '0;
      p_q     <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      g_q     <= g_d;
      pg_q    <= pg_d;
      p_q     <= p_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
    end
  end

  assign g_o     = g_q;
  assign pg_o    = pg_q;
  assign p_o     = p_q;
  assign cin_o   = cin_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/prefix_carry_pipe.sv
// Pipelined Kogge-Stone carry generator: stage 0 forms p/g, LOG2N prefix levels follow,
// and the last level is reshaped into per-bit carries for the sum stage.
module prefix_carry_pipe
  import prefix_carry_pipe_pkg::*;
#(
  parameter int unsigned N = ADDER_N
) (
  input  logic                 clk,
  input  logic                 rst,
  prefix_carry_pipe_if.slave   bus
);

  localparam int unsigned LOG2N = $clog2(N);

  logic adv;

  logic [N-1:0] g0_d, g0_q;
  logic [N-1:0] p0_d, p0_q;
  logic         cin0_d, cin0_q;
  logic         valid0_d, valid0_q;

  logic [N-1:0] g_w     [LOG2N+1];
  logic [N-1:0] pg_w    [LOG2N+1];
  logic [N-1:0] p_w     [LOG2N+1];
  logic         cin_w   [LOG2N+1];
  logic         valid_w [LOG2N+1];

  // Single global advance: the whole pipe moves unless the output is blocked.
  assign adv          = !valid_w[LOG2N] || bus.out_ready;
  assign bus.in_ready = adv;

  // Stage 0: cin is folded into g[0] so the prefix tree needs no separate carry-in.
  always_comb begin
    g0_d     = g0_q;
    p0_d     = p0_q;
    cin0_d   = cin0_q;
    valid0_d = valid0_q;
    if (adv) begin
      p0_d     = bus.A ^ bus.B;
      g0_d     = bus.A & bus.B;
      g0_d[0]  = g0_d[0] | (p0_d[0] & bus.cin);
      cin0_d   = bus.cin;
      valid0_d = bus.in_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g0_q     <= '0;
      p0_q     <= '0;
      cin0_q   <= 1'b0;
      valid0_q <= 1'b0;
    end else begin
      g0_q     <= g0_d;
      p0_q     <= p0_d;
      cin0_q   <= cin0_d;
      valid0_q <= valid0_d;
    end
  end

  assign g_w[0]     = g0_q;
  assign pg_w[0]    = p0_q;
  assign p_w[0]     = p0_q;
  assign cin_w[0]   = cin0_q;
  assign valid_w[0] = valid0_q;

  for (genvar k = 1; k <= LOG2N; k++) begin : g_lvl
    prefix_level #(
      .N    (N),
      .SPAN (2 ** (k - 1))
    ) u_lvl (
      .clk     (clk),
      .rst     (rst),
      .en      (adv),
      .g_i     (g_w[k-1]),
      .pg_i    (pg_w[k-1]),
      .p_i     (p_w[k-1]),
      .cin_i   (cin_w[k-1]),
      .valid_i (valid_w[k-1]),
      .g_o     (g_w[k]),
      .pg_o    (pg_w[k]),
      .p_o     (p_w[k]),
      .cin_o   (cin_w[k]),
      .valid_o (valid_w[k])
    );
  end

  // Final group propagate is not needed once every prefix reaches bit 0.
  logic unused_pg;
  assign unused_pg = ^pg_w[LOG2N];

  assign bus.out_valid = valid_w[LOG2N];
  assign bus.P         = p_w[LOG2N];
  assign bus.C         = {g_w[LOG2N][N-2:0], cin_w[LOG2N]};
  assign bus.cout      = g_w[LOG2N][N-1];

endmodule

// File: tb/tb_prefix_carry_pipe.sv
// Self-checking bench for prefix_carry_pipe at N=8 and N=32 against an arithmetic model.
module tb_prefix_carry_pipe;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  int res8   = 0;
  int res32  = 0;
  int acc8   = 0;
  int acc32  = 0;

  logic [64:0] q8  [$];
  logic [64:0] q32 [$];

  prefix_carry_pipe_if #(.N(8))  if8  ();
  prefix_carry_pipe_if #(.N(32)) if32 ();

  prefix_carry_pipe #(.N(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  prefix_carry_pipe #(.N(32)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {cout, C, P}: C is recovered from the true sum as S ^ A ^ B.
  function automatic logic [64:0] model(int unsigned n, logic [31:0] a, logic [31:0] b, logic ci);
    logic [32:0] s;
    logic [31:0] mask;
    logic [31:0] p;
    logic [31:0] c;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    s    = 33'(a) + 33'(b) + 33'(ci);
    p    = (a ^ b) & mask;
    c    = (s[31:0] ^ a ^ b) & mask;
    return (65'(s[n]) << (2 * n)) | (65'(c) << n) | 65'(p);
  endfunction

  task automatic chk(string tag, logic [64:0] obs, logic [64:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle, score both outputs, record accepted operands, advance.
  task automatic cycle();
    logic [64:0] o;
    #3;
    if (if8.out_valid && if8.out_ready) begin
      o = 65'({if8.cout, if8.C, if8.P});
      chk("pending8", 65'(q8.size() > 0), 65'(1));
      if (q8.size() > 0) chk("result8", o, q8.pop_front());
      res8++;
    end
    if (if32.out_valid && if32.out_ready) begin
      o = 65'({if32.cout, if32.C, if32.P});
      chk("pending32", 65'(q32.size() > 0), 65'(1));
      if (q32.size() > 0) chk("result32", o, q32.pop_front());
      res32++;
    end
    if (if8.in_valid && if8.in_ready) begin
      q8.push_back(model(8, 32'(if8.A), 32'(if8.B), if8.cin));
      acc8++;
    end
    if (if32.in_valid && if32.in_ready) begin
      q32.push_back(model(32, if32.A, if32.B, if32.cin));
      acc32++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic single8(string tag, logic [7:0] a, logic [7:0] b, logic ci,
                         logic [7:0] ep, logic [7:0] ec, logic eco);
    int n;
    if8.in_valid = 1'b1;
    if8.A        = a;
    if8.B        = b;
    if8.cin      = ci;
    cycle();
    if8.in_valid = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 10) begin
      cycle();
      n++;
    end
    chk({tag, "_latency"}, 65'(n), 65'(3));
    chk({tag, "_P"},    65'(if8.P),    65'(ep));
    chk({tag, "_C"},    65'(if8.C),    65'(ec));
    chk({tag, "_cout"}, 65'(if8.cout), 65'(eco));
    chk({tag, "_sum"},  65'({if8.cout, if8.P ^ if8.C}), 65'(9'(a) + 9'(b) + 9'(ci)));
    cycle();
  endtask

  initial begin
    int n;
    int base;
    int cyc;

    rst           = 1'b1;
    if8.in_valid  = 1'b0;
    if8.A         = '0;
    if8.B         = '0;
    if8.cin       = 1'b0;
    if8.out_ready = 1'b1;
    if32.in_valid  = 1'b0;
    if32.A         = '0;
    if32.B         = '0;
    if32.cin       = 1'b0;
    if32.out_ready = 1'b1;

    @(posedge clk);
    #1;
    chk("rst_out_valid", 65'(if8.out_valid), 65'(0));
    chk("rst_P",         65'(if8.P),         65'(0));
    chk("rst_C",         65'(if8.C),         65'(0));
    chk("rst_cout",      65'(if8.cout),      65'(0));
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 65'(if8.in_ready), 65'(1));

    single8("ff_01", 8'hFF, 8'h01, 1'b0, 8'hFE, 8'hFE, 1'b1);
    single8("0f_01", 8'h0F, 8'h01, 1'b0, 8'h0E, 8'h1E, 1'b0);
    single8("aa_55", 8'hAA, 8'h55, 1'b1, 8'hFF, 8'hFF, 1'b1);

    // Back-to-back stream, then a 3-cycle downstream stall on the first result.
    base = res8;
    if8.in_valid = 1'b1;
    if8.A = 8'h00; if8.B = 8'h00; if8.cin = 1'b1; cycle();
    if8.A = 8'h0F; if8.B = 8'h01; if8.cin = 1'b0; cycle();
    if8.A = 8'hFF; if8.B = 8'h01; if8.cin = 1'b0; cycle();
    if8.in_valid = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 10) begin
      cycle();
      n++;
    end
    chk("stream_first_valid", 65'(if8.out_valid), 65'(1));
    if8.out_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("stall_in_ready", 65'(if8.in_ready), 65'(0));
      chk("stall_hold", 65'({if8.out_valid, if8.cout, if8.C, if8.P}), 65'({1'b1, 1'b0, 8'h01, 8'h00}));
      cycle();
    end
    if8.out_ready = 1'b1;
    n = 0;
    while (q8.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("stream_count", 65'(res8 - base), 65'(3));

    // Reset with two operands in flight.
    if8.in_valid = 1'b1;
    if8.A = 8'h12; if8.B = 8'h34; if8.cin = 1'b0; cycle();
    if8.A = 8'h56; if8.B = 8'h78; if8.cin = 1'b1; cycle();
    if8.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("flight_out_valid", 65'(if8.out_valid), 65'(0));
    chk("flight_C",         65'(if8.C),         65'(0));
    q8.delete();
    q32.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("flight_in_ready", 65'(if8.in_ready), 65'(1));
    base = res8;
    repeat (8) cycle();
    chk("flight_no_ghost", 65'(res8 - base), 65'(0));

    // Random regression on both widths with random downstream back-pressure.
    acc8  = 0;
    acc32 = 0;
    cyc   = 0;
    while ((acc8 < 10000 || acc32 < 10000 || q8.size() > 0 || q32.size() > 0) && cyc < 60000) begin
      if8.in_valid   = (acc8 < 10000) && ($urandom_range(0, 3) != 0);
      if8.A          = 8'($urandom);
      if8.B          = 8'($urandom);
      if8.cin        = 1'($urandom);
      if8.out_ready  = ($urandom_range(0, 2) != 0);
      if32.in_valid  = (acc32 < 10000) && ($urandom_range(0, 3) != 0);
      if32.A         = $urandom;
      if32.B         = $urandom;
      if32.cin       = 1'($urandom);
      if32.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      cyc++;
    end
    if8.in_valid  = 1'b0;
    if32.in_valid = 1'b0;
    chk("rand_acc8",    65'(acc8),       65'(10000));
    chk("rand_acc32",   65'(acc32),      65'(10000));
    chk("rand_drain8",  65'(q8.size()),  65'(0));
    chk("rand_drain32", 65'(q32.size()), 65'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefix_carry_pipe.md
PREFIX_CARRY_PIPE -- requirements
Module: prefix_carry_pipe

Interface
REQ-001 The block SHALL have one parameter: N, default 8, operand bitwidth; a power of two, 2 to 64.
REQ-002 The block SHALL derive the localparam LOG2N = log2(N), the number of prefix levels.
REQ-003 clk  input  1  the single clock; all registers update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operands A, B and cin are presented.
REQ-006 in_ready  output  1  the block accepts operands this cycle.
REQ-007 A, B  input  N each  addend operands.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 out_valid  output  1  P, C and cout hold a completed result.
REQ-010 out_ready  input  1  the downstream sum stage consumes the result.
REQ-011 P  output  N  propagate vector, A^B of the accepted operands.
REQ-012 C  output  N  carry into each bit; C[0] = cin; feeds the sum stage, which forms S = P^C.
REQ-013 cout  output  1  carry out of bit N-1.

Function
REQ-014 A transfer SHALL occur on a rising edge where valid and ready are both high, on either side.
REQ-015 The pipeline SHALL use one global advance enable: adv = !out_valid || out_ready; in_ready = adv.
REQ-016 Stage 0 SHALL register p = A^B, g = A&B, cin and a valid bit, with g[0] replaced by g[0] | (p[0]&cin).
REQ-017 Stages 1..LOG2N SHALL each register one Kogge-Stone level (span 2^(k-1)).
  - Black cell on bits i >= span: G' = G_i | (P_i & G_{i-span}); P' = P_i & P_{i-span}.
  - Lower bits pass through unchanged.
  - Each stage carries along the original p vector, cin and its valid bit.
REQ-018 Output forming:
  - C[0] = cin; C[i] = Gprefix[i-1] for i >= 1.
  - cout = Gprefix[N-1].
  - P = the original p vector.
REQ-019 Latency SHALL be LOG2N+1 edges. For N=8, an operand accepted on edge t is presented with out_valid high after edge t+3, with no stalls.
REQ-020 Throughput SHALL be one result per cycle while out_ready is high.
REQ-021 Bubbles (valid = 0 stages) SHALL advance in lockstep with the other stages and are not collapsed.
REQ-022 When adv is low, every stage register SHALL hold its value, and out_valid, P, C and cout SHALL remain stable until the transfer.
REQ-023 A simultaneous output transfer and input acceptance in the same cycle SHALL lose no data and duplicate none.
REQ-024 Results SHALL emerge in acceptance order.
REQ-025 Arithmetic SHALL be exact modulo 2^N, with cout as the (N+1)th bit; no signed interpretation.

Reset
REQ-026 While rst is high, all stage valid bits and out_valid SHALL be 0, and P, C and cout SHALL be 0, regardless of clk.
REQ-027 Operands in flight when rst asserts SHALL be discarded; no partial result SHALL appear after release.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-029 A shared header file SHALL hold the default width constant (ADDER_N = 8), used by this block and the sum stage.
REQ-030 The header SHALL hold no block-private constants.
REQ-031 One sub-module prefix_level SHALL implement one registered Kogge-Stone level.
  - Parameters: N, SPAN.
  - Ports: clk, rst, en, in/out G, Pgrp, p, cin, valid.
  - Instantiated LOG2N times through a generate loop.
REQ-032 Stage 0 and output forming SHALL reside in prefix_carry_pipe.

Verification
REQ-033 A=0xFF, B=0x01, cin=0, out_ready=1 -> after 4 edges: P=0xFE, C=0xFE, cout=1; P^C=0x00.
REQ-034 A=0x0F, B=0x01, cin=0 -> P=0x0E, C=0x1E, cout=0; P^C=0x10.
REQ-035 A=0xAA, B=0x55, cin=1 -> P=0xFF, C=0xFF, cout=1; P^C=0x00.
REQ-036 Back-to-back stream and stall:
  - Stimulus: {0x00+0x00 cin=1}, {0x0F+0x01}, {0xFF+0x01}, with out_ready low for 3 cycles once out_valid rises.
  - Required: in_ready falls.
  - Required: the first result (P=0x00, C=0x01, cout=0) stays stable.
  - Required: all three results emerge in order with none lost.
REQ-037 Reset with 2 operands in flight -> out_valid=0, C=0 immediately; no result appears after release; in_ready=1.
REQ-038 Random regression: 10k vectors at N=8 and N=32 with random out_ready -> {cout, P^C} equals A+B+cin for every result, in order.
